// File: rtl/lab4_pio_pkg.sv
// ----------------------------------------------------------------------------
// lab4_pio_pkg
//   Definitions shared by the lab 4 parallel I/O slaves (LED output PIO and
//   keys input PIO): the word addresses of the s1 register map and the
//   encodings of the edge-capture selection parameter.
// ----------------------------------------------------------------------------
package lab4_pio_pkg;

    // Word addresses on the s1 slave. Address 1 is reserved and reads as 0.
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // EDGE_TYPE parameter values: which transitions are latched into EDGECAP.
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/lab4_pio_sync_edge.sv
// ----------------------------------------------------------------------------
// lab4_pio_sync_edge
//   Brings asynchronous input pins into the clk domain through a chain of
//   SYNC_STAGES flops, keeps the previous synchronized value, and produces a
//   one-cycle edge pulse per bit for the transitions selected by EDGE_TYPE.
//
// Ports
//   clk        in   1      system clock
//   reset      in   1      asynchronous, active-high reset
//   pins       in   WIDTH  asynchronous external pins
//   sync_q     out  WIDTH  synchronized pin level (last chain stage)
//   edge_pulse out  WIDTH  selected-edge pulses, combinational from sync_q/prev
// ----------------------------------------------------------------------------
module lab4_pio_sync_edge
    import lab4_pio_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_FALL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] sync_q,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [WIDTH-1:0] sync_ff [SYNC_STAGES];
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= '0;
            end
            prev <= '0;
        end else begin
            sync_ff[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= sync_ff[i-1];
            end
            prev <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign sync_q = sync_ff[SYNC_STAGES-1];
    assign rise   = sync_q & ~prev;
    assign fall   = ~sync_q & prev;

    // The pulse is combinational so the capture register sets on the clock
    // after sync_q changes, giving SYNC_STAGES+1 cycles pin-to-EDGECAP.
    always_comb begin
        edge_pulse = rise | fall;
        if (EDGE_TYPE == EDGE_RISE) begin
            edge_pulse = rise;
        end else if (EDGE_TYPE == EDGE_FALL) begin
            edge_pulse = fall;
        end
    end

endmodule

// File: rtl/lab4part1_keys_pio.sv
// ----------------------------------------------------------------------------
// lab4part1_keys_pio
//   Avalon-MM slave input PIO for pushbuttons/switches. Exposes the
//   synchronized pin level (DATA), an interrupt mask (IRQMASK) and a
//   write-one-to-clear edge capture register (EDGECAP), and drives a level
//   interrupt when a masked captured edge is pending.
//
//   Build option: define LAB4_KEYS_IRQ_EN to include the IRQMASK register and
//   the irq output. Without it, address 2 reads 0 and ignores writes, irq is
//   tied low, and EDGECAP remains available for polling.
//
// Ports
//   clk        in   1      system clock
//   reset      in   1      asynchronous, active-high reset
//   address    in   2      word register select
//   chipselect in   1      slave select
//   write_n    in   1      active-low write strobe, qualified by chipselect
//   writedata  in   32     write data (bits above WIDTH ignored)
//   in_port    in   WIDTH  asynchronous external pins
//   readdata   out  32     registered, zero-extended read data
//   irq        out  1      level interrupt, active-high
//
// Bus protocol: there is no waitrequest, so a write is accepted in every
// cycle where chipselect is high and write_n is low. Reads have no strobe:
// readdata is reloaded every clock from the register selected by address,
// so the value for an address presented in cycle N is valid in cycle N+1
// and shows register contents from before any write in cycle N.
// ----------------------------------------------------------------------------
module lab4part1_keys_pio
    import lab4_pio_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int EDGE_TYPE   = EDGE_FALL,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] cap_clear;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             unused_bits;

    lab4_pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk        (clk),
        .reset      (reset),
        .pins       (in_port),
        .sync_q     (sync_q),
        .edge_pulse (edge_pulse)
    );

    assign wr_en     = chipselect & ~write_n;
    assign cap_clear = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    // Writedata bits above WIDTH have no destination.
    assign unused_bits = &{1'b0, writedata};

    // Clear is applied before the new edge is ORed in, so an edge arriving in
    // the same cycle as its clear is kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~cap_clear) | edge_pulse;
        end
    end

`ifdef LAB4_KEYS_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_en && address == ADDR_IRQMASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            irq <= |(edge_capture & irq_mask);
        end
    end
`else
    assign irq_mask = '0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux = 32'(sync_q);
            ADDR_IRQMASK: rd_mux = 32'(irq_mask);
            ADDR_EDGECAP: rd_mux = 32'(edge_capture);
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule
